val2_shifter_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational operand-2 generator; sits between the ID/EXE register and the ALU.
- Implements all ARM data-processing shifter modes: rotated immediate, immediate-amount shift, register-amount shift (Rs[7:0]) and RRX.
- Produces val2 plus shifter carry-out, with valid/ready flow control and a pipeline flush.

---
 rtl/val2_shifter_pipe_pkg.sv | 45 ++++
 rtl/val2_shift_core.sv | 85 ++++++++
 rtl/val2_shifter_pipe.sv | 106 ++++++++++
 tb/tb_val2_shifter_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/val2_shifter_pipe_pkg.sv
// Shared encodings and the stage-1 decode record for the operand-2 shifter pipe.
package val2_shifter_pipe_pkg;

  localparam int   REGISTER_LEN = 32;
  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;

  typedef enum logic [1:0] {
    LSL_SHIFT_STATE = 2'b00,
    LSR_SHIFT_STATE = 2'b01,
    ASR_SHIFT_STATE = 2'b10,
    ROR_SHIFT_STATE = 2'b11
  } shift_t;

  // Mode flags are mutually exclusive in priority order: mem > imm > rrx > zero_amt.
  typedef struct packed {
    logic        mem;       // load/store offset: zero-extended 12-bit field
    logic        imm;       // rotated 8-bit immediate
    logic        rrx;       // immediate ROR #0
    logic        zero_amt;  // shift amount of zero (not RRX)
    logic        reg_amt;   // amount came from Rs[7:0]
    shift_t      shift;
    logic [7:0]  amount;
    logic [11:0] operand;
  } decode_t;

  // Resolves shift type, amount and mode flags from the instruction fields.
  function automatic decode_t decode_operand(input logic [11:0] op,
                                             input logic        immd,
                                             input logic        is_mem,
                                             input logic [7:0]  rs_lo);
    decode_t d;
    d          = '0;
    d.operand  = op;
    d.shift    = shift_t'(op[6:5]);
    d.reg_amt  = op[4];
    d.amount   = op[4] ? rs_lo : {3'b000, op[11:7]};
    d.mem      = is_mem;
    d.imm      = !is_mem && immd;
    d.rrx      = !is_mem && !immd && !op[4] && (op[11:7] == 5'd0) && (op[6:5] == 2'b11);
    d.zero_amt = !is_mem && !immd && (d.amount == 8'd0) && !d.rrx;
    return d;
  endfunction

endpackage

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter: turns a decode record plus Rm/carry into val2 and carry-out.
module val2_shift_core
  import val2_shifter_pipe_pkg::*;
#(
  parameter int DATA_W = REGISTER_LEN
) (
  input  decode_t           dec_i,
  input  logic [DATA_W-1:0] rm_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] val2_o,
  output logic              carry_o
);

  localparam int          LW  = $clog2(DATA_W);
  localparam logic [31:0] W32 = 32'(DATA_W);

  logic [31:0]       amt32, rot32, imm_r32;
  logic [LW-1:0]     rot, rot_m1, lsl_idx, rsh_idx;
  logic [DATA_W-1:0] zimm, imm_rot, lsl_v, lsr_v, asr_v, ror_v;
  logic              in_range;

  // Candidate results for every mode, evaluated in parallel.
  always_comb begin
    amt32    = {24'd0, dec_i.amount};
    rot      = LW'(amt32);
    rot32    = 32'(rot);
    rot_m1   = rot - LW'(1);   // wraps to W-1 when rot==0, which is the carry for ROR by a multiple of W
    lsl_idx  = LW'(W32 - amt32);
    rsh_idx  = LW'(amt32 - 32'd1);
    in_range = (amt32 <= W32);
    imm_r32  = {27'd0, dec_i.operand[11:8], 1'b0};
    zimm     = DATA_W'(dec_i.operand[7:0]);
    imm_rot  = (zimm >> imm_r32) | (zimm << (W32 - imm_r32));
    lsl_v    = rm_i << amt32;
    lsr_v    = rm_i >> amt32;
    asr_v    = $signed(rm_i) >>> amt32;
    ror_v    = (rm_i >> rot32) | (rm_i << (W32 - rot32));
  end

  // Mode select; amounts >= W fall out of the shift operators as 0 / sign fill.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    val2_o  = rm_i;
    carry_o = carry_i;
    if (dec_i.mem) begin
      val2_o  = DATA_W'(dec_i.operand);
      carry_o = carry_i;
    end else if (dec_i.imm) begin
      val2_o  = imm_rot;
      carry_o = (imm_r32 == 32'd0) ? carry_i : imm_rot[DATA_W-1];
    end else if (dec_i.rrx) begin
      val2_o  = {carry_i, rm_i[DATA_W-1:1]};
      carry_o = rm_i[0];
    end else if (dec_i.zero_amt) begin
      // Immediate LSR/ASR #0 encode a shift by W; every other zero amount passes Rm through.
      if (!dec_i.reg_amt && dec_i.shift == LSR_SHIFT_STATE) begin
        val2_o  = '0;
        carry_o = rm_i[DATA_W-1];
      end else if (!dec_i.reg_amt && dec_i.shift == ASR_SHIFT_STATE) begin
        val2_o  = {DATA_W{rm_i[DATA_W-1]}};
        carry_o = rm_i[DATA_W-1];
      end
    end else begin
      unique case (dec_i.shift)
        LSL_SHIFT_STATE: begin
          val2_o  = lsl_v;
          carry_o = in_range ? rm_i[lsl_idx] : 1'b0;
        end
        LSR_SHIFT_STATE: begin
          val2_o  = lsr_v;
          carry_o = in_range ? rm_i[rsh_idx] : 1'b0;
        end
        ASR_SHIFT_STATE: begin
          val2_o  = asr_v;
          carry_o = in_range ? rm_i[rsh_idx] : rm_i[DATA_W-1];
        end
        default: begin
          val2_o  = ror_v;
          carry_o = rm_i[rot_m1];
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_shifter_pipe.sv
// Two-stage operand-2 generator: stage 1 decodes, stage 2 registers the barrel result.
module val2_shifter_pipe
  import val2_shifter_pipe_pkg::*;
#(
  parameter int DATA_W = REGISTER_LEN,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic [11:0]       shift_operand,
  input  logic              immd,
  input  logic              is_mem_command,
  input  logic              carry_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2_out,
  output logic              carry_out,
  output logic [TAG_W-1:0]  tag_out
);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s1_ready, s2_ready, s1_load, s2_load;
  decode_t           s1_dec_q, s1_dec_d;
  logic [DATA_W-1:0] s1_rm_q;
  logic              s1_carry_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic              carry_q, carry_d;
  logic [TAG_W-1:0]  tag_q;
  logic              unused_rs_hi;

  assign unused_rs_hi = ^rs[DATA_W-1:8];

  // Handshake, stage enables and next valid state; flush overrides everything.
  always_comb begin
    s2_ready   = !s2_valid_q || out_ready;
    s1_ready   = !s1_valid_q || s2_ready;
    in_ready   = rst && s1_ready;
    s1_load    = in_valid && in_ready && !flush;
    s2_load    = s1_valid_q && s2_ready && !flush;
    s1_valid_d = s1_ready ? in_valid : s1_valid_q;
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    if (flush) begin
      s1_valid_d = DISABLE;
      s2_valid_d = DISABLE;
    end
    s1_dec_d = decode_operand(shift_operand, immd, is_mem_command, rs[7:0]);
  end

  // Valid bits for both stages.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) begin
      s1_valid_q <= DISABLE;
      s2_valid_q <= DISABLE;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage-1 payload capture.
  always_ff @(posedge clk) begin
    // NOTE: payload flops are not reset; s1_valid_q alone qualifies them.
    if (s1_load) begin
      s1_dec_q   <= s1_dec_d;
      s1_rm_q    <= rm;
      s1_carry_q <= carry_in;
      s1_tag_q   <= tag_in;
    end
  end

  val2_shift_core #(.DATA_W(DATA_W)) u_core (
    .dec_i   (s1_dec_q),
    .rm_i    (s1_rm_q),
    .carry_i (s1_carry_q),
    .val2_o  (val2_d),
    .carry_o (carry_d)
  );

  // Output register: cleared on reset, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      val2_q  <= '0;
      carry_q <= 1'b0;
      tag_q   <= '0;
    end else if (s2_load) begin
      val2_q  <= val2_d;
      carry_q <= carry_d;
      tag_q   <= s1_tag_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign val2_out  = val2_q;
  assign carry_out = carry_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_val2_shifter_pipe.sv
// Directed self-checking bench for val2_shifter_pipe (DATA_W=32, TAG_W=8).
module tb_val2_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] rm, rs;
  logic [11:0] shift_operand;
  logic        immd, is_mem_command, carry_in;
  logic [7:0]  tag_in, tag_out;
  logic        out_valid, out_ready, carry_out;
  logic [31:0] val2_out;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [11:0] op;
    logic        immd;
    logic        mem;
    logic        cin;
    logic [31:0] exp_v;
    logic        exp_c;
  } vec_t;

  val2_shifter_pipe #(.DATA_W(32), .TAG_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rm             (rm),
    .rs             (rs),
    .shift_operand  (shift_operand),
    .immd           (immd),
    .is_mem_command (is_mem_command),
    .carry_in       (carry_in),
    .tag_in         (tag_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .val2_out       (val2_out),
    .carry_out      (carry_out),
    .tag_out        (tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish first");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string n, logic [31:0] r, logic [31:0] s, logic [11:0] o,
                              logic im, logic me, logic ci, logic [31:0] ev, logic ec);
    vec_t v;
    v.name = n; v.rm = r; v.rs = s; v.op = o; v.immd = im; v.mem = me;
    v.cin = ci; v.exp_v = ev; v.exp_c = ec;
    return v;
  endfunction

  // One beat in with out_ready=1; reports out_valid after edge 1 and the result after edge 2.
  task automatic run_beat(input vec_t v, input logic [7:0] tag, output logic ov_early,
                          output logic ov, output logic [31:0] val, output logic c,
                          output logic [7:0] t);
    @(negedge clk);
    rm = v.rm; rs = v.rs; shift_operand = v.op; immd = v.immd;
    is_mem_command = v.mem; carry_in = v.cin; tag_in = tag;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    ov_early = out_valid;
    @(negedge clk);
    ov = out_valid; val = val2_out; c = carry_out; t = tag_out;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    rm = 32'hDEADBEEF; rs = 32'h0; shift_operand = 12'h4FF; immd = 1'b1;
    is_mem_command = 1'b0; carry_in = 1'b1; tag_in = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, val2_out, carry_out, tag_out} !== 42'd0)
      $display("FAIL reset_outputs: got valid=%b val2=%h c=%b tag=%h, need all zero",
               out_valid, val2_out, carry_out, tag_out);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b need 0", in_ready);
    else passed++;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b need 1", in_ready);
    else passed++;
  endtask

  task automatic test_rot_imm();
    vec_t tbl[$];
    logic e, ov, c;
    logic [31:0] v;
    logic [7:0] t;
    tbl.push_back(mk("imm_4ff", 32'h0, 32'h0, 12'h4FF, 1, 0, 1, 32'hFF000000, 1));
    tbl.push_back(mk("imm_0ff", 32'h0, 32'h0, 12'h0FF, 1, 0, 0, 32'h000000FF, 0));
    tbl.push_back(mk("imm_1ff", 32'h0, 32'h0, 12'h1FF, 1, 0, 0, 32'hC000003F, 1));
    tbl.push_back(mk("imm_2f0", 32'h0, 32'h0, 12'h2F0, 1, 0, 1, 32'h0000000F, 0));
    tbl.push_back(mk("mem_abc", 32'h12345678, 32'h0, 12'hABC, 1, 1, 1, 32'h00000ABC, 1));
    foreach (tbl[i]) begin
      run_beat(tbl[i], 8'(i + 1), e, ov, v, c, t);
      total++;
      if ({e, ov, t} !== {1'b0, 1'b1, 8'(i + 1)})
        $display("FAIL %s_hs: got early=%b valid=%b tag=%h need 0 1 %h", tbl[i].name, e, ov, t, 8'(i + 1));
      else passed++;
      total++;
      if (v !== tbl[i].exp_v) $display("FAIL %s_val: got %h need %h", tbl[i].name, v, tbl[i].exp_v);
      else passed++;
      total++;
      if (c !== tbl[i].exp_c) $display("FAIL %s_c: got %b need %b", tbl[i].name, c, tbl[i].exp_c);
      else passed++;
    end
  endtask

  task automatic test_imm_shift();
    vec_t tbl[$];
    logic e, ov, c;
    logic [31:0] v;
    logic [7:0] t;
    tbl.push_back(mk("lsr_0",  32'h80000001, 32'h0, 12'h020, 0, 0, 0, 32'h00000000, 1));
    tbl.push_back(mk("rrx",    32'h00000003, 32'h0, 12'h060, 0, 0, 1, 32'h80000001, 1));
    tbl.push_back(mk("lsl_0",  32'h12345678, 32'h0, 12'h000, 0, 0, 1, 32'h12345678, 1));
    tbl.push_back(mk("asr_0",  32'h80000000, 32'h0, 12'h040, 0, 0, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk("lsl_4",  32'hF000000F, 32'h0, 12'h200, 0, 0, 0, 32'h000000F0, 1));
    tbl.push_back(mk("lsr_1",  32'h00000003, 32'h0, 12'h0A0, 0, 0, 0, 32'h00000001, 1));
    tbl.push_back(mk("asr_4",  32'h80000010, 32'h0, 12'h240, 0, 0, 1, 32'hF8000001, 0));
    tbl.push_back(mk("ror_8",  32'h12345678, 32'h0, 12'h460, 0, 0, 1, 32'h78123456, 0));
    foreach (tbl[i]) begin
      run_beat(tbl[i], 8'(8'h20 + i), e, ov, v, c, t);
      total++;
      if ({e, ov, t} !== {1'b0, 1'b1, 8'(8'h20 + i)})
        $display("FAIL %s_hs: got early=%b valid=%b tag=%h need 0 1 %h", tbl[i].name, e, ov, t, 8'(8'h20 + i));
      else passed++;
      total++;
      if (v !== tbl[i].exp_v) $display("FAIL %s_val: got %h need %h", tbl[i].name, v, tbl[i].exp_v);
      else passed++;
      total++;
      if (c !== tbl[i].exp_c) $display("FAIL %s_c: got %b need %b", tbl[i].name, c, tbl[i].exp_c);
      else passed++;
    end
  endtask

  task automatic test_reg_shift();
    vec_t tbl[$];
    logic e, ov, c;
    logic [31:0] v;
    logic [7:0] t;
    tbl.push_back(mk("rlsl_32",  32'h00000001, 32'd32,        12'h010, 0, 0, 0, 32'h00000000, 1));
    tbl.push_back(mk("rlsl_33",  32'h00000001, 32'd33,        12'h010, 0, 0, 1, 32'h00000000, 0));
    tbl.push_back(mk("rlsl_0",   32'h00000001, 32'd0,         12'h010, 0, 0, 1, 32'h00000001, 1));
    tbl.push_back(mk("rlsl_31",  32'h00000003, 32'd31,        12'h010, 0, 0, 0, 32'h80000000, 1));
    tbl.push_back(mk("rror_32",  32'h80000001, 32'd32,        12'h070, 0, 0, 0, 32'h80000001, 1));
    tbl.push_back(mk("rror_1",   32'h80000001, 32'd1,         12'h070, 0, 0, 0, 32'hC0000000, 1));
    tbl.push_back(mk("rror_36",  32'h0000000F, 32'd36,        12'h070, 0, 0, 0, 32'hF0000000, 1));
    tbl.push_back(mk("rror_0",   32'h80000001, 32'h00000100,  12'h070, 0, 0, 0, 32'h80000001, 0));
    tbl.push_back(mk("rlsr_32",  32'h80000000, 32'd32,        12'h030, 0, 0, 0, 32'h00000000, 1));
    tbl.push_back(mk("rlsr_33",  32'hFFFFFFFF, 32'd33,        12'h030, 0, 0, 1, 32'h00000000, 0));
    tbl.push_back(mk("rlsr_4hi", 32'h0000001F, 32'h00000104,  12'h030, 0, 0, 0, 32'h00000001, 1));
    tbl.push_back(mk("rasr_40n", 32'h80000000, 32'd40,        12'h050, 0, 0, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk("rasr_40p", 32'h7FFFFFFF, 32'd40,        12'h050, 0, 0, 1, 32'h00000000, 0));
    foreach (tbl[i]) begin
      run_beat(tbl[i], 8'(8'h40 + i), e, ov, v, c, t);
      total++;
      if ({e, ov, t} !== {1'b0, 1'b1, 8'(8'h40 + i)})
        $display("FAIL %s_hs: got early=%b valid=%b tag=%h need 0 1 %h", tbl[i].name, e, ov, t, 8'(8'h40 + i));
      else passed++;
      total++;
      if (v !== tbl[i].exp_v) $display("FAIL %s_val: got %h need %h", tbl[i].name, v, tbl[i].exp_v);
      else passed++;
      total++;
      if (c !== tbl[i].exp_c) $display("FAIL %s_c: got %b need %b", tbl[i].name, c, tbl[i].exp_c);
      else passed++;
    end
  endtask

  // Six mem-mode beats (val2 = 0x100+i, tag = 0x10+i, C = i[0]) with out_ready low in cycles 3..5.
  task automatic test_back_to_back();
    int   sent = 0;
    int   got  = 0;
    logic saw_low = 1'b0;
    logic prev_stall = 1'b0;
    logic extra = 1'b0;
    logic [41:0] snap = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      flush = 1'b0; immd = 1'b0; is_mem_command = 1'b1; rm = 32'h0; rs = 32'h0;
      if (sent < 6) begin
        in_valid = 1'b1;
        shift_operand = 12'(12'h100 + sent);
        tag_in = 8'(8'h10 + sent);
        carry_in = sent[0];
      end else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        total++;
        if ({out_valid, val2_out, carry_out, tag_out} !== snap)
          $display("FAIL b2b_hold: got %h need %h", {out_valid, val2_out, carry_out, tag_out}, snap);
        else passed++;
      end
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        total++;
        if (val2_out !== 32'(32'h100 + got) || tag_out !== 8'(8'h10 + got) || carry_out !== got[0])
          $display("FAIL b2b_beat%0d: got val2=%h tag=%h c=%b need %h %h %b", got, val2_out,
                   tag_out, carry_out, 32'(32'h100 + got), 8'(8'h10 + got), got[0]);
        else passed++;
        got++;
      end
      prev_stall = out_valid && !out_ready;
      snap = {out_valid, val2_out, carry_out, tag_out};
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got !== 6) $display("FAIL b2b_count: got %0d results need 6", got);
    else passed++;
    total++;
    if (saw_low !== 1'b1) $display("FAIL b2b_in_ready_drop: got saw_low=%b need 1", saw_low);
    else passed++;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) $display("FAIL b2b_no_dup: got extra out_valid=%b need 0", extra);
    else passed++;
  endtask

  task automatic test_flush();
    logic stale = 1'b0;
    logic e, ov, c;
    logic [31:0] v;
    logic [7:0] t;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0; immd = 1'b0; is_mem_command = 1'b1;
    in_valid = 1'b1; shift_operand = 12'hAAA; tag_in = 8'hA1; carry_in = 1'b0;
    @(negedge clk);
    shift_operand = 12'hBBB; tag_in = 8'hB2;
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, val2_out} !== {1'b1, 1'b0, 32'h00000AAA})
      $display("FAIL flush_fill: got valid=%b in_ready=%b val2=%h need 1 0 00000aaa",
               out_valid, in_ready, val2_out);
    else passed++;
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; shift_operand = 12'hCCC; tag_in = 8'hC3;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_kill: got out_valid=%b need 0", out_valid);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    total++;
    if (stale !== 1'b0) $display("FAIL flush_stale: got stale out_valid=%b need 0", stale);
    else passed++;
    run_beat(mk("post", 32'h0, 32'h0, 12'h123, 0, 1, 1, 32'h123, 1), 8'hD4, e, ov, v, c, t);
    total++;
    if ({e, ov, v, c, t} !== {1'b0, 1'b1, 32'h00000123, 1'b1, 8'hD4})
      $display("FAIL flush_recover: got early=%b valid=%b val2=%h c=%b tag=%h need 0 1 00000123 1 d4",
               e, ov, v, c, t);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0; immd = 1'b0; is_mem_command = 1'b1;
    in_valid = 1'b1; shift_operand = 12'h5A5; tag_in = 8'h77; carry_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, val2_out, carry_out, tag_out} !== {1'b1, 32'h000005A5, 1'b1, 8'h77})
      $display("FAIL mid_fill: got valid=%b val2=%h c=%b tag=%h need 1 000005a5 1 77",
               out_valid, val2_out, carry_out, tag_out);
    else passed++;
    rst = 1'b0; in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL mid_in_ready: got %b need 0", in_ready);
    else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, val2_out, carry_out, tag_out} !== 42'd0)
      $display("FAIL mid_reset: got valid=%b val2=%h c=%b tag=%h need all zero",
               out_valid, val2_out, carry_out, tag_out);
    else passed++;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_rot_imm();
    test_imm_shift();
    test_reg_shift();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
